pc_stack_unit: RTL

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack and optional single-level interrupt vectoring.
// Define PC_STACK_INT_EN to compile in the interrupt logic (INT_REQ/SEI/CLI/RETI); otherwise those inputs are ignored.
module pc_stack_unit #(
  parameter int unsigned     PC_W    = 10,
  parameter int unsigned     DEPTH   = 32,
  parameter logic [PC_W-1:0] INT_VEC = '1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PC_LD,
  input  logic                     PC_INC,
  input  logic [1:0]               PC_SEL,
  input  logic [PC_W-1:0]          FROM_IR,
  input  logic                     PUSH,
  input  logic                     POP,
  input  logic                     INT_REQ,
  input  logic                     SEI,
  input  logic                     CLI,
  input  logic                     RETI,
  output logic [PC_W-1:0]          PC_COUNT,
  output logic [PC_W-1:0]          STK_TOP,
  output logic [$clog2(DEPTH):0]   STK_LVL,
  output logic                     STK_FULL,
  output logic                     STK_EMPTY,
  output logic                     STK_ERR,
  output logic                     INT_EN,
  output logic                     INT_ACK
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [PC_W-1:0] mem [DEPTH];

  logic [PC_W-1:0] pc_q, pc_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic            err_q, err_d;
  logic            int_en_q, int_en_d;
  logic            ack_q;

  logic            empty_c, full_c;
  logic [AW-1:0]   top_idx_c;
  logic [PC_W-1:0] top_c, pc_inc_c;
  logic            accept_c, reti_c;
  logic            we_c;
  logic [AW-1:0]   wa_c;
  logic [PC_W-1:0] wd_c;

`ifdef PC_STACK_INT_EN
  assign accept_c = INT_REQ & int_en_q;
  assign reti_c   = RETI;
`else
  logic unused_int_c;
  assign unused_int_c = ^{INT_REQ, SEI, CLI, RETI};
  assign accept_c     = 1'b0;
  assign reti_c       = 1'b0;
`endif

  assign empty_c   = (lvl_q == '0);
  assign full_c    = (lvl_q == LW'(DEPTH));
  assign top_idx_c = AW'(lvl_q - LW'(1));
  assign top_c     = empty_c ? '0 : mem[top_idx_c];
  assign pc_inc_c  = pc_q + PC_W'(1);

  // Next-state: interrupt accept, then RETI, then load/increment with independent stack op.
  always_comb begin
    pc_d     = pc_q;
    lvl_d    = lvl_q;
    err_d    = err_q;
    int_en_d = 1'b0;
    we_c     = 1'b0;
    wa_c     = AW'(lvl_q);
    wd_c     = pc_inc_c;

    if (accept_c) begin
      pc_d = INT_VEC;
      if (full_c) begin
        err_d = 1'b1;
      end else begin
        we_c  = 1'b1;
        wd_c  = pc_q;
        lvl_d = lvl_q + LW'(1);
      end
    end else if (reti_c) begin
      pc_d = top_c;
      if (empty_c) err_d = 1'b1;
      else         lvl_d = lvl_q - LW'(1);
    end else begin
      if (PC_LD) begin
        case (PC_SEL)
          2'b00: pc_d = FROM_IR;
          2'b01: begin
            pc_d = top_c;
            if (empty_c) err_d = 1'b1;
          end
          2'b10: pc_d = INT_VEC;
          2'b11: pc_d = '0;
        endcase
      end else if (PC_INC) begin
        pc_d = pc_inc_c;
      end

      // Push+pop on a non-empty stack overwrites the top in place.
      if (PUSH && POP && !empty_c) begin
        we_c = 1'b1;
        wa_c = top_idx_c;
      end else if (PUSH) begin
        if (full_c) begin
          err_d = 1'b1;
        end else begin
          we_c  = 1'b1;
          lvl_d = lvl_q + LW'(1);
        end
      end else if (POP) begin
        if (empty_c) err_d = 1'b1;
        else         lvl_d = lvl_q - LW'(1);
      end
    end

`ifdef PC_STACK_INT_EN
    if (accept_c)        int_en_d = 1'b0;
    else if (CLI)        int_en_d = 1'b0;
    else if (SEI || reti_c) int_en_d = 1'b1;
    else                 int_en_d = int_en_q;
`endif
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q     <= '0;
      lvl_q    <= '0;
      err_q    <= 1'b0;
      int_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      lvl_q    <= lvl_d;
      err_q    <= err_d;
      int_en_q <= int_en_d;
      ack_q    <= accept_c;
    end
  end

  // Entry storage is not reset; the level pointer alone defines valid contents.
  always_ff @(posedge CLK) begin
    if (we_c) mem[wa_c] <= wd_c;
  end

  assign PC_COUNT  = pc_q;
  assign STK_TOP   = top_c;
  assign STK_LVL   = lvl_q;
  assign STK_FULL  = full_c;
  assign STK_EMPTY = empty_c;
  assign STK_ERR   = err_q;
  assign INT_EN    = int_en_q;
  assign INT_ACK   = ack_q;

endmodule
